// File: rtl/glitch_filter_debounce_if.sv
// Interface bundle for the debounce filter: enable strobe and raw inputs in,
// debounced levels and edge events out.
interface glitch_filter_debounce_if #(
    parameter int NUMBER_OF_SIGNALS = 8
);
    logic                         iEna;
    logic [NUMBER_OF_SIGNALS-1:0] iSignal;
    logic [NUMBER_OF_SIGNALS-1:0] oFilterSignals;
    logic [NUMBER_OF_SIGNALS-1:0] oRise;
    logic [NUMBER_OF_SIGNALS-1:0] oFall;
    logic                         oChanged;

    modport master (
        output iEna,
        output iSignal,
        input  oFilterSignals,
        input  oRise,
        input  oFall,
        input  oChanged
    );

    modport slave (
        input  iEna,
        input  iSignal,
        output oFilterSignals,
        output oRise,
        output oFall,
        output oChanged
    );
endinterface

// File: rtl/glitch_filter_debounce.sv
// Multi-channel debounce filter: per-channel synchroniser, stability-window
// counter and registered rise/fall event pulses.
module glitch_filter_debounce #(
    parameter int                           NUMBER_OF_SIGNALS = 8,
    parameter int                           FILTER_CYCLES     = 4,
    parameter int                           SYNC_STAGES       = 2,
    parameter logic [NUMBER_OF_SIGNALS-1:0] RST_VALUE         = '0
) (
    input  logic                     iClk,
    input  logic                     iARst,
    input  logic                     iSRst_n,
    glitch_filter_debounce_if.slave  bus
);
    localparam int CNT_W = $clog2(FILTER_CYCLES > 2 ? FILTER_CYCLES : 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [NUMBER_OF_SIGNALS-1:0] filt_all;
    logic [NUMBER_OF_SIGNALS-1:0] rise_all;
    logic [NUMBER_OF_SIGNALS-1:0] fall_all;
    logic [NUMBER_OF_SIGNALS-1:0] rise_next_all;
    logic [NUMBER_OF_SIGNALS-1:0] fall_next_all;
    logic                         changed_q;
    logic                         changed_d;

    generate
        for (genvar gi = 0; gi < NUMBER_OF_SIGNALS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   filt_q;
            logic                   filt_d;
            logic                   rise_q;
            logic                   rise_d;
            logic                   fall_q;
            logic                   fall_d;
            logic                   sync_bit;

            assign sync_bit = sync_q[SYNC_STAGES-1];

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], bus.iSignal[gi]};
                cnt_d  = cnt_q;
                filt_d = filt_q;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (!iSRst_n) begin
                    // Synchronous reset also flushes the synchroniser so a
                    // partially-seen level cannot leak into the next window.
                    sync_d = {SYNC_STAGES{RST_VALUE[gi]}};
                    cnt_d  = '0;
                    filt_d = RST_VALUE[gi];
                end else if (bus.iEna) begin
                    if (sync_bit == filt_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        filt_d = sync_bit;
                        rise_d = sync_bit;
                        fall_d = ~sync_bit;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge iClk or posedge iARst) begin
                if (iARst) begin
                    sync_q <= {SYNC_STAGES{RST_VALUE[gi]}};
                    cnt_q  <= '0;
                    filt_q <= RST_VALUE[gi];
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign filt_all[gi]      = filt_q;
            assign rise_all[gi]      = rise_q;
            assign fall_all[gi]      = fall_q;
            assign rise_next_all[gi] = rise_d;
            assign fall_next_all[gi] = fall_d;
        end
    endgenerate

    // Built from the next-state pulses so oChanged lines up with oRise/oFall.
    assign changed_d = |(rise_next_all | fall_next_all);

    always_ff @(posedge iClk or posedge iARst) begin
        if (iARst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign bus.oFilterSignals = filt_all;
    assign bus.oRise          = rise_all;
    assign bus.oFall          = fall_all;
    assign bus.oChanged       = changed_q;
endmodule

// File: tb/tb_glitch_filter_debounce.sv
// Self-checking bench for glitch_filter_debounce: directed scenarios plus a
// randomized run compared against a window-history reference model.
module tb_glitch_filter_debounce;
    localparam int          NS  = 4;
    localparam int          FC  = 4;
    localparam int          SS  = 2;
    localparam logic [NS-1:0] RST = 4'b0101;
    localparam int unsigned MASK = (1 << FC) - 1;

    logic iClk = 1'b0;
    logic iARst = 1'b0;
    logic iSRst_n = 1'b1;

    glitch_filter_debounce_if #(.NUMBER_OF_SIGNALS(NS)) bus ();

    glitch_filter_debounce #(
        .NUMBER_OF_SIGNALS(NS),
        .FILTER_CYCLES    (FC),
        .SYNC_STAGES      (SS),
        .RST_VALUE        (RST)
    ) dut (
        .iClk   (iClk),
        .iARst  (iARst),
        .iSRst_n(iSRst_n),
        .bus    (bus.slave)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model: delay line for the synchroniser, and per channel the
    // history of enabled samples since the last accepted level.
    logic [NS-1:0] m_pipe [SS];
    logic [NS-1:0] m_filt, m_rise, m_fall;
    logic          m_chg;
    int unsigned   m_hist [NS];
    int            m_len  [NS];

    task automatic model_reset();
        for (int s = 0; s < SS; s++) m_pipe[s] = RST;
        m_filt = RST;
        m_rise = '0;
        m_fall = '0;
        m_chg  = 1'b0;
        for (int c = 0; c < NS; c++) begin
            m_hist[c] = 0;
            m_len[c]  = 0;
        end
    endtask

    // One clock edge; inputs are captured before the edge, outputs settle 1ns after.
    task automatic step();
        logic [NS-1:0] sig;
        logic [NS-1:0] s;
        logic          en;
        logic          srn;
        int unsigned   target;
        sig = bus.iSignal;
        en  = bus.iEna;
        srn = iSRst_n;
        @(posedge iClk);
        #1;
        if (!srn) begin
            model_reset();
        end else begin
            s = m_pipe[SS-1];
            for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = sig;
            m_rise = '0;
            m_fall = '0;
            if (en) begin
                for (int c = 0; c < NS; c++) begin
                    m_hist[c] = ((m_hist[c] << 1) | int'(s[c])) & MASK;
                    m_len[c]++;
                    target = m_filt[c] ? 0 : MASK;
                    if (m_len[c] >= FC && m_hist[c] == target) begin
                        m_filt[c] = s[c];
                        if (s[c]) m_rise[c] = 1'b1;
                        else      m_fall[c] = 1'b1;
                        m_hist[c] = 0;
                        m_len[c]  = 0;
                    end
                end
            end
            m_chg = |(m_rise | m_fall);
        end
    endtask

    task automatic test_reset();
        bus.iEna    = 1'b1;
        bus.iSignal = 4'b1111;
        #1 iARst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== {RST, 4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_initial: got filt=%b rise=%b fall=%b chg=%b, want filt=%b no pulses",
                     bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, RST);
        end
        @(negedge iClk);
        iARst = 1'b0;
        model_reset();
        for (int n = 0; n < 8; n++) step();
        checks++;
        if (bus.oFilterSignals !== 4'b1111) begin
            errors++;
            $display("FAIL reset_preload: got filt=%b want 1111", bus.oFilterSignals);
        end
        #3 iARst = 1'b1;
        #1;
        checks++;
        if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== {RST, 4'b0, 4'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async_immediate: got filt=%b rise=%b fall=%b chg=%b, want filt=%b no pulses",
                     bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, RST);
        end
        bus.iSignal = RST;
        @(negedge iClk);
        iARst = 1'b0;
        model_reset();
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== {RST, 4'b0, 4'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_quiet cycle %0d: got filt=%b rise=%b fall=%b chg=%b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged);
            end
        end
    endtask

    task automatic test_clean_rise();
        bus.iSignal = 4'b0111;
        for (int n = 1; n <= 7; n++) begin
            logic [12:0] want;
            step();
            if (n < 6)       want = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            else if (n == 6) want = {4'b0111, 4'b0010, 4'b0000, 1'b1};
            else             want = {4'b0111, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== want) begin
                errors++;
                $display("FAIL clean_rise edge %0d: got %b_%b_%b_%b want %b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, want);
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        int falls;
        for (int n = 0; n < 13; n++) begin
            bus.iSignal = (n < 3) ? 4'b1111 : 4'b0111;
            step();
            checks++;
            if (bus.oFilterSignals[3] !== 1'b0 || (bus.oRise | bus.oFall) !== 4'b0 || bus.oChanged !== 1'b0) begin
                errors++;
                $display("FAIL glitch_short cycle %0d: got filt=%b rise=%b fall=%b chg=%b want filt[3]=0 no pulses",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged);
            end
        end
        rises = 0;
        falls = 0;
        for (int n = 0; n < 16; n++) begin
            bus.iSignal = (n < 4) ? 4'b1111 : 4'b0111;
            step();
            rises += int'(bus.oRise[3]);
            falls += int'(bus.oFall[3]);
        end
        checks++;
        if (rises != 1 || falls != 1 || bus.oFilterSignals !== 4'b0111) begin
            errors++;
            $display("FAIL glitch_full_window: got rises=%0d falls=%0d filt=%b want 1 1 0111",
                     rises, falls, bus.oFilterSignals);
        end
    endtask

    task automatic test_gated();
        int exp_edge;
        int en_cnt;
        exp_edge = 0;
        en_cnt   = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n >= SS + 1 && n % 3 == 0) begin
                en_cnt++;
                if (en_cnt == FC && exp_edge == 0) exp_edge = n;
            end
        end
        bus.iSignal = 4'b0110;
        for (int n = 1; n <= 18; n++) begin
            logic [12:0] want;
            bus.iEna = (n % 3 == 0);
            step();
            if (n < exp_edge)       want = {4'b0111, 4'b0000, 4'b0000, 1'b0};
            else if (n == exp_edge) want = {4'b0110, 4'b0000, 4'b0001, 1'b1};
            else                    want = {4'b0110, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== want) begin
                errors++;
                $display("FAIL gated edge %0d: got %b_%b_%b_%b want %b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, want);
            end
        end
        bus.iEna = 1'b1;
    endtask

    task automatic test_sync_reset();
        bus.iSignal = 4'b0010;
        for (int n = 1; n <= 12; n++) begin
            logic [12:0] want;
            iSRst_n = (n != 5);
            step();
            if (n < 5)       want = {4'b0110, 4'b0000, 4'b0000, 1'b0};
            else if (n < 11) want = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            else if (n == 11) want = {4'b0010, 4'b0010, 4'b0101, 1'b1};
            else             want = {4'b0010, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== want) begin
                errors++;
                $display("FAIL sync_reset edge %0d: got %b_%b_%b_%b want %b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, want);
            end
        end
        iSRst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        bus.iSignal = 4'b0101;
        for (int n = 0; n < 10; n++) step();
        bus.iSignal = 4'b1010;
        for (int n = 1; n <= 7; n++) begin
            logic [12:0] want;
            step();
            if (n < 6)       want = {4'b0101, 4'b0000, 4'b0000, 1'b0};
            else if (n == 6) want = {4'b1010, 4'b1010, 4'b0101, 1'b1};
            else             want = {4'b1010, 4'b0000, 4'b0000, 1'b0};
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== want) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got %b_%b_%b_%b want %b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [NS-1:0] sig;
            sig = bus.iSignal;
            for (int c = 0; c < NS; c++)
                if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
            bus.iSignal = sig;
            bus.iEna    = ($urandom_range(0, 3) != 0);
            iSRst_n     = ($urandom_range(0, 59) != 0);
            step();
            checks++;
            if ({bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged} !== {m_filt, m_rise, m_fall, m_chg}) begin
                errors++;
                $display("FAIL random cycle %0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         n, bus.oFilterSignals, bus.oRise, bus.oFall, bus.oChanged,
                         m_filt, m_rise, m_fall, m_chg);
            end
        end
        iSRst_n  = 1'b1;
        bus.iEna = 1'b1;
    endtask

    initial begin
        bus.iEna    = 1'b1;
        bus.iSignal = RST;
        model_reset();
        test_reset();
        test_clean_rise();
        test_glitch();
        test_gated();
        test_sync_reset();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/glitch_filter_debounce.md
Name: glitch_filter_debounce

Overview:
- Multi-channel debounce filter. Generalises the one-sample glitch filter to a configurable stability window, built-in input synchronisation, and per-channel edge-event outputs.
- Each channel passes a new level to its output only after FILTER_CYCLES consecutive enabled samples at that level.
- Sits between asynchronous board inputs (buttons, presence pins, fault lines) and the control logic that consumes clean levels and edge events.

Parameters:
- NUMBER_OF_SIGNALS, 8, number of independent channels (≥1).
- FILTER_CYCLES, 4, consecutive enabled samples required to accept a new level (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (≥2).
- RST_VALUE, 0, per-bit reset level of the synchroniser and filtered outputs (NUMBER_OF_SIGNALS bits wide).

Ports:
- iClk  input  1  clock.
- iARst  input  1  reset, asynchronous, active-high.
- iSRst_n  input  1  synchronous reset, active-low.
- iEna  input  1  sample-enable strobe, active-high.
- iSignal  input  NUMBER_OF_SIGNALS  raw asynchronous inputs.
- oFilterSignals  output  NUMBER_OF_SIGNALS  debounced levels.
- oRise  output  NUMBER_OF_SIGNALS  one-clock pulse when a channel's filtered level goes 0→1.
- oFall  output  NUMBER_OF_SIGNALS  one-clock pulse when a channel's filtered level goes 1→0.
- oChanged  output  1  OR-reduction of (oRise | oFall), registered.

Behaviour:
- Clocking and reset
  - One clock domain: iClk.
  - Reset is asynchronous and active-high: iARst.
- Reset values (iARst=1, or iSRst_n=0 at a clock edge)
  - Synchroniser flops = RST_VALUE; oFilterSignals = RST_VALUE.
  - All counters = 0; oRise = oFall = 0; oChanged = 0.
- Reset priority
  - iARst overrides everything.
  - iSRst_n overrides iEna.
  - Reset mid-window discards partial counts; no edge pulse is ever generated by reset itself.
- Synchroniser
  - SYNC_STAGES-deep shift per channel, clocked every cycle regardless of iEna.
  - sync[i] is the last stage.
- Per-channel filter: counter cnt[i], width clog2(max(FILTER_CYCLES,2)). On each edge with iEna=1:
  - If sync[i] == oFilterSignals[i]: cnt[i] <= 0. Any glitch shorter than the window is discarded.
  - Else if cnt[i] == FILTER_CYCLES-1: oFilterSignals[i] <= sync[i], cnt[i] <= 0, and oRise[i] or oFall[i] <= 1 according to the new level.
  - Else: cnt[i] <= cnt[i]+1.
  - cnt never exceeds FILTER_CYCLES-1; no wrap.
  - FILTER_CYCLES=1 accepts every differing enabled sample immediately.
- iEna=0
  - Counters and oFilterSignals hold.
  - oRise, oFall and oChanged are 0.
  - Synchroniser keeps shifting.
- Pulses
  - oRise, oFall and oChanged are registered and high for exactly one clock, in the same cycle oFilterSignals updates.
  - Channels are fully independent; several channels may pulse in the same cycle.
- Latency, iEna held high
  - A level stable from edge k (the first edge sampling it) appears on oFilterSignals after edge k+SYNC_STAGES+FILTER_CYCLES-1.
  - Total delay is SYNC_STAGES+FILTER_CYCLES edges.
- Interrupted window, iEna pulsed
  - Only enabled samples count; disabled cycles neither advance nor clear cnt.
  - A sample equal to the current output clears cnt even after a partial window.

Test Plan:
Bench configuration for all scenarios: NUMBER_OF_SIGNALS=4, FILTER_CYCLES=4, SYNC_STAGES=2, RST_VALUE=4'b0101, iEna=1 unless stated.
1. Reset values: assert iARst mid-cycle, iSignal=4'b1111.
   - Required: all outputs update immediately, without waiting for a clock edge: oFilterSignals=4'b0101, oRise=oFall=0, oChanged=0.
   - After release with iSignal=4'b0101: no pulses for 20 cycles.
2. Clean rise: iSignal[1] 0→1 held.
   - Required: oFilterSignals=4'b0111 after exactly 6 edges.
   - oRise=4'b0010 and oChanged=1 for one cycle; oFall=0.
3. Glitch rejection: iSignal[3] high for 3 cycles then low.
   - Required: oFilterSignals[3] stays 0 and no pulses.
   - A 4-cycle pulse on iSignal[3] yields oRise[3] once; its 4-cycle return yields oFall[3] once.
4. Gated sampling: iEna high every 3rd cycle, iSignal[0] 1→0 held.
   - Required: output changes only on the 4th enabled sample after the synchroniser delay.
   - oFall=4'b0001 appears in that enabled cycle only.
5. Sync reset mid-window: iSignal[2] 1→0 and, after 2 enabled samples, iSRst_n=0 for one cycle.
   - Required: outputs return to 4'b0101, cnt cleared, no pulse.
   - The change is accepted only after a full new window.
6. Simultaneous channels: iSignal 4'b0101→4'b1010 in one cycle.
   - Required: after 6 edges oFilterSignals=4'b1010, oRise=4'b1010 and oFall=4'b0101 in the same cycle, oChanged=1 for one cycle.
